// File: rtl/crc_mfsk_frame_link_pkg.sv
// Shared types and size helpers for the CRC framing / FSK symbol sequencing link.
package crc_fsk_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic {
        RX_HUNT    = 1'b0,
        RX_COLLECT = 1'b1
    } rx_state_t;

    localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;

    function automatic int frame_w(input int data_w, input int crc_w);
        return data_w + crc_w;
    endfunction

    function automatic int n_sym(input int data_w, input int crc_w, input int sym_bits);
        return (data_w + crc_w) / sym_bits;
    endfunction

    // Width of a counter holding values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/crc_mfsk_frame_link_crc_calc.sv
// Combinational MSB-first CRC: remainder of data*x^CRC_W mod poly, init 0, no output XOR.
module crc_calc
    import crc_fsk_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEFAULT)
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    logic [CRC_W-1:0] crc_v;
    logic             fb;

    always_comb begin
        crc_v = '0;
        fb    = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb    = crc_v[CRC_W-1] ^ data_i[i];
            crc_v = crc_v << 1;
            if (fb) begin
                crc_v = crc_v ^ CRC_POLY;
            end
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/crc_mfsk_frame_link.sv
// CRC framing engine: TX appends a CRC and sequences FSK symbols; RX reassembles and checks frames.
module crc_mfsk_frame_link
    import crc_fsk_pkg::*;
#(
    parameter int               DATA_W          = 8,
    parameter int               CRC_W           = 8,
    parameter logic [CRC_W-1:0] CRC_POLY        = CRC_W'(CRC_POLY_DEFAULT),
    parameter int               SYM_BITS        = 1,
    parameter int               SAMPLES_PER_SYM = 16
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DATA_W-1:0]   tx_data,
    output logic                tx_active,
    output logic                sym_strobe,
    output logic [SYM_BITS-1:0] tx_sym,
    input  logic                rx_sym_valid,
    input  logic [SYM_BITS-1:0] rx_sym,
    input  logic                rx_sof,
    output logic                rx_valid,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_crc_ok,
    output logic [15:0]         rx_err_cnt
);

    localparam int FRAME_W = frame_w(DATA_W, CRC_W);
    localparam int N_SYM   = n_sym(DATA_W, CRC_W, SYM_BITS);
    localparam int SAMP_W  = cnt_w(SAMPLES_PER_SYM);
    localparam int SYMC_W  = cnt_w(N_SYM);
    localparam int RXC_W   = cnt_w(N_SYM + 1);

    // ---------------- TX ----------------
    tx_state_t           tx_state_q;
    logic [FRAME_W-1:0]  tx_shreg_q;
    logic [FRAME_W-1:0]  tx_shreg_d;
    logic [FRAME_W-1:0]  tx_code;
    logic [CRC_W-1:0]    tx_crc;
    logic [SAMP_W-1:0]   tx_samp_q;
    logic [SYMC_W-1:0]   tx_symc_q;
    logic                tx_strobe_q;
    logic [SYM_BITS-1:0] tx_sym_q;
    logic                tx_ready_q;
    logic                tx_samp_tc;
    logic                tx_last_sym;

    crc_calc #(
        .DATA_W  (DATA_W),
        .CRC_W   (CRC_W),
        .CRC_POLY(CRC_POLY)
    ) u_tx_crc (
        .data_i(tx_data),
        .crc_o (tx_crc)
    );

    assign tx_code     = {tx_data, tx_crc};
    assign tx_shreg_d  = tx_shreg_q << SYM_BITS;
    assign tx_samp_tc  = (tx_samp_q == SAMP_W'(SAMPLES_PER_SYM - 1));
    assign tx_last_sym = (tx_symc_q == SYMC_W'(N_SYM - 1));

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= TX_IDLE;
            tx_shreg_q  <= '0;
            tx_samp_q   <= '0;
            tx_symc_q   <= '0;
            tx_strobe_q <= 1'b0;
            tx_sym_q    <= '0;
            tx_ready_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_strobe_q <= 1'b0;
                    tx_sym_q    <= '0;
                    if (tx_valid && tx_ready_q) begin
                        tx_shreg_q  <= tx_code;
                        tx_samp_q   <= '0;
                        tx_symc_q   <= '0;
                        tx_strobe_q <= 1'b1;
                        tx_sym_q    <= tx_code[FRAME_W-1 -: SYM_BITS];
                        tx_ready_q  <= 1'b0;
                        tx_state_q  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_samp_tc) begin
                        tx_samp_q <= '0;
                        if (tx_last_sym) begin
                            // The word just finished; a waiting word is taken on the IDLE cycle.
                            tx_strobe_q <= 1'b0;
                            tx_sym_q    <= '0;
                            tx_ready_q  <= 1'b1;
                            tx_state_q  <= TX_IDLE;
                        end else begin
                            tx_shreg_q  <= tx_shreg_d;
                            tx_symc_q   <= tx_symc_q + SYMC_W'(1);
                            tx_strobe_q <= 1'b1;
                            tx_sym_q    <= tx_shreg_d[FRAME_W-1 -: SYM_BITS];
                        end
                    end else begin
                        tx_samp_q   <= tx_samp_q + SAMP_W'(1);
                        tx_strobe_q <= 1'b0;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_ready   = tx_ready_q;
    assign tx_active  = (tx_state_q == TX_SEND);
    assign sym_strobe = tx_strobe_q;
    assign tx_sym     = tx_sym_q;

    // ---------------- RX ----------------
    rx_state_t          rx_state_q;
    logic [FRAME_W-1:0] rx_shreg_q;
    logic [FRAME_W-1:0] rx_frame_d;
    logic [RXC_W-1:0]   rx_cnt_q;
    logic [RXC_W-1:0]   rx_cnt_d;
    logic               rx_take;
    logic               rx_done;
    logic [DATA_W-1:0]  rx_payload_d;
    logic [CRC_W-1:0]   rx_crc;
    logic               rx_match;
    logic               rx_valid_q;
    logic [DATA_W-1:0]  rx_data_q;
    logic               rx_ok_q;
    logic [15:0]        rx_err_q;

    // An SOF symbol always restarts the frame, whether hunting or mid-collect.
    always_comb begin
        rx_take    = rx_sym_valid && (rx_sof || (rx_state_q == RX_COLLECT));
        rx_frame_d = rx_sof ? FRAME_W'(rx_sym) : ((rx_shreg_q << SYM_BITS) | FRAME_W'(rx_sym));
        rx_cnt_d   = rx_sof ? RXC_W'(1) : (rx_cnt_q + RXC_W'(1));
        rx_done    = rx_take && (rx_cnt_d == RXC_W'(N_SYM));
    end

    assign rx_payload_d = rx_frame_d[FRAME_W-1 -: DATA_W];

    crc_calc #(
        .DATA_W  (DATA_W),
        .CRC_W   (CRC_W),
        .CRC_POLY(CRC_POLY)
    ) u_rx_crc (
        .data_i(rx_payload_d),
        .crc_o (rx_crc)
    );

    assign rx_match = (rx_crc == rx_frame_d[CRC_W-1:0]);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_HUNT;
            rx_shreg_q <= '0;
            rx_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_ok_q    <= 1'b0;
            rx_err_q   <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rx_take) begin
                if (rx_done) begin
                    rx_state_q <= RX_HUNT;
                    rx_shreg_q <= '0;
                    rx_cnt_q   <= '0;
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= rx_payload_d;
                    rx_ok_q    <= rx_match;
                    if (!rx_match && (rx_err_q != 16'hFFFF)) begin
                        rx_err_q <= rx_err_q + 16'd1;
                    end
                end else begin
                    rx_state_q <= RX_COLLECT;
                    rx_shreg_q <= rx_frame_d;
                    rx_cnt_q   <= rx_cnt_d;
                end
            end
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_crc_ok  = rx_ok_q;
    assign rx_err_cnt = rx_err_q;

endmodule

// File: tb/tb_crc_mfsk_frame_link.sv
// Directed bench for crc_mfsk_frame_link: 2FSK and 4FSK instances sharing clock and reset.
module tb_crc_mfsk_frame_link;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic reset;

    logic        tx_valid, tx_ready, tx_active, sym_strobe;
    logic [7:0]  tx_data;
    logic [0:0]  tx_sym;
    logic        rx_sym_valid, rx_sof, rx_valid, rx_crc_ok;
    logic [0:0]  rx_sym;
    logic [7:0]  rx_data;
    logic [15:0] rx_err_cnt;

    logic        q_tx_valid, q_tx_ready, q_tx_active, q_sym_strobe;
    logic [7:0]  q_tx_data;
    logic [1:0]  q_tx_sym;
    logic        q_rx_sym_valid, q_rx_sof, q_rx_valid, q_rx_crc_ok;
    logic [1:0]  q_rx_sym;
    logic [7:0]  q_rx_data;
    logic [15:0] q_rx_err_cnt;

    int total = 0;
    int bad   = 0;

    crc_mfsk_frame_link #(.SYM_BITS(1), .SAMPLES_PER_SYM(16)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_active(tx_active), .sym_strobe(sym_strobe), .tx_sym(tx_sym),
        .rx_sym_valid(rx_sym_valid), .rx_sym(rx_sym), .rx_sof(rx_sof),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_crc_ok(rx_crc_ok), .rx_err_cnt(rx_err_cnt)
    );

    crc_mfsk_frame_link #(.SYM_BITS(2), .SAMPLES_PER_SYM(4)) dut4 (
        .sys_clk(sys_clk), .reset(reset),
        .tx_valid(q_tx_valid), .tx_ready(q_tx_ready), .tx_data(q_tx_data),
        .tx_active(q_tx_active), .sym_strobe(q_sym_strobe), .tx_sym(q_tx_sym),
        .rx_sym_valid(q_rx_sym_valid), .rx_sym(q_rx_sym), .rx_sof(q_rx_sof),
        .rx_valid(q_rx_valid), .rx_data(q_rx_data), .rx_crc_ok(q_rx_crc_ok), .rx_err_cnt(q_rx_err_cnt)
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Walks one 2FSK frame from its first SEND cycle until tx_ready returns.
    task automatic collect2(output int n, output int strobes, output int holderr, output logic [15:0] seq);
        logic [0:0] held;
        n = 0; strobes = 0; holderr = 0; seq = '0; held = '0;
        while (tx_ready === 1'b0 && n < 400) begin
            if (sym_strobe === 1'b1) begin
                strobes++;
                seq  = {seq[14:0], tx_sym};
                held = tx_sym;
            end else if (tx_sym !== held) begin
                holderr++;
            end
            n++;
            tick();
        end
    endtask

    task automatic collect4(output int n, output int strobes, output int holderr, output logic [15:0] seq);
        logic [1:0] held;
        n = 0; strobes = 0; holderr = 0; seq = '0; held = '0;
        while (q_tx_ready === 1'b0 && n < 100) begin
            if (q_sym_strobe === 1'b1) begin
                strobes++;
                seq  = {seq[13:0], q_tx_sym};
                held = q_tx_sym;
            end else if (q_tx_sym !== held) begin
                holderr++;
            end
            n++;
            tick();
        end
    endtask

    // Sends the first nsym bits of frame MSB-first with an idle cycle after each.
    task automatic rx_send(input logic [15:0] frame, input int nsym, input bit use_sof, output int pulses);
        pulses = 0;
        for (int i = 0; i < nsym; i++) begin
            rx_sym_valid = 1'b1;
            rx_sym       = frame[15-i];
            rx_sof       = use_sof && (i == 0);
            tick();
            if (rx_valid === 1'b1) pulses++;
            rx_sym_valid = 1'b0;
            rx_sof       = 1'b0;
            tick();
            if (rx_valid === 1'b1) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rx_valid === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tx_valid = 0; tx_data = 0; rx_sym_valid = 0; rx_sym = 0; rx_sof = 0;
        q_tx_valid = 0; q_tx_data = 0; q_rx_sym_valid = 0; q_rx_sym = 0; q_rx_sof = 0;
        tick(); tick();
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%0h want=1", tx_ready); end
        total++; if (tx_active !== 1'b0) begin bad++; $display("FAIL reset_tx_active got=%0h want=0", tx_active); end
        total++; if (sym_strobe !== 1'b0) begin bad++; $display("FAIL reset_sym_strobe got=%0h want=0", sym_strobe); end
        total++; if (tx_sym !== 1'b0) begin bad++; $display("FAIL reset_tx_sym got=%0h want=0", tx_sym); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%0h want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%0h want=0", rx_data); end
        total++; if (rx_crc_ok !== 1'b0) begin bad++; $display("FAIL reset_rx_crc_ok got=%0h want=0", rx_crc_ok); end
        total++; if (rx_err_cnt !== 16'h0) begin bad++; $display("FAIL reset_rx_err_cnt got=%0h want=0", rx_err_cnt); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_tx_2fsk;
        int n, strobes, holderr;
        logic [15:0] seq;
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        collect2(n, strobes, holderr, seq);
        total++; if (n != 256) begin bad++; $display("FAIL tx2_ready_low got=%0d want=256", n); end
        total++; if (strobes != 16) begin bad++; $display("FAIL tx2_strobes got=%0d want=16", strobes); end
        total++; if (seq !== 16'hA572) begin bad++; $display("FAIL tx2_symbols got=%h want=a572", seq); end
        total++; if (holderr != 0) begin bad++; $display("FAIL tx2_sym_hold got=%0d want=0", holderr); end
        total++; if (tx_sym !== 1'b0) begin bad++; $display("FAIL tx2_idle_sym got=%0h want=0", tx_sym); end
        total++; if (tx_active !== 1'b0) begin bad++; $display("FAIL tx2_idle_active got=%0h want=0", tx_active); end
    endtask

    task automatic test_tx_4fsk;
        int n, strobes, holderr;
        logic [15:0] seq;
        q_tx_data = 8'hA5; q_tx_valid = 1'b1;
        tick();
        q_tx_valid = 1'b0;
        collect4(n, strobes, holderr, seq);
        total++; if (n != 32) begin bad++; $display("FAIL tx4_ready_low got=%0d want=32", n); end
        total++; if (strobes != 8) begin bad++; $display("FAIL tx4_strobes got=%0d want=8", strobes); end
        total++; if (seq !== 16'hA572) begin bad++; $display("FAIL tx4_symbols got=%h want=a572", seq); end
        total++; if (holderr != 0) begin bad++; $display("FAIL tx4_sym_hold got=%0d want=0", holderr); end
    endtask

    task automatic test_back_to_back;
        int n, strobes, holderr, gap, n2;
        logic [15:0] seq;
        q_tx_data = 8'hA5; q_tx_valid = 1'b1;
        tick();
        n = 0;
        while (q_tx_ready === 1'b0 && n < 100) begin n++; tick(); end
        gap = 0;
        q_tx_data = 8'h5A;
        while (q_tx_ready === 1'b1 && gap < 10) begin gap++; tick(); end
        q_tx_valid = 1'b0;
        collect4(n2, strobes, holderr, seq);
        total++; if (n != 32) begin bad++; $display("FAIL b2b_first_len got=%0d want=32", n); end
        total++; if (gap != 1) begin bad++; $display("FAIL b2b_idle_gap got=%0d want=1", gap); end
        total++; if (seq !== 16'h5A81) begin bad++; $display("FAIL b2b_second_frame got=%h want=5a81", seq); end
    endtask

    task automatic test_loopback;
        int n, pulses;
        bit first;
        logic [7:0] got_data;
        logic got_ok;
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        first = 1'b1; pulses = 0; n = 0; got_data = '0; got_ok = 1'b0;
        while (n < 300) begin
            if (rx_valid === 1'b1) begin pulses++; got_data = rx_data; got_ok = rx_crc_ok; end
            if (sym_strobe === 1'b1) begin
                rx_sym_valid = 1'b1; rx_sym = tx_sym; rx_sof = first; first = 1'b0;
            end else begin
                rx_sym_valid = 1'b0; rx_sof = 1'b0;
            end
            n++;
            tick();
        end
        rx_sym_valid = 1'b0; rx_sof = 1'b0;
        total++; if (pulses != 1) begin bad++; $display("FAIL loop_rx_valid_count got=%0d want=1", pulses); end
        total++; if (got_data !== 8'hFF) begin bad++; $display("FAIL loop_rx_data got=%h want=ff", got_data); end
        total++; if (got_ok !== 1'b1) begin bad++; $display("FAIL loop_crc_ok got=%0h want=1", got_ok); end
        total++; if (rx_err_cnt !== 16'h0) begin bad++; $display("FAIL loop_err_cnt got=%0h want=0", rx_err_cnt); end
    endtask

    task automatic test_rx_bad;
        int p;
        rx_send(16'h0100, 16, 1'b1, p);
        total++; if (p != 1) begin bad++; $display("FAIL bad_rx_valid_count got=%0d want=1", p); end
        total++; if (rx_data !== 8'h01) begin bad++; $display("FAIL bad_rx_data got=%h want=01", rx_data); end
        total++; if (rx_crc_ok !== 1'b0) begin bad++; $display("FAIL bad_crc_ok got=%0h want=0", rx_crc_ok); end
        total++; if (rx_err_cnt !== 16'd1) begin bad++; $display("FAIL bad_err_cnt got=%0h want=1", rx_err_cnt); end
    endtask

    task automatic test_abort;
        int p1, p2;
        rx_send(16'hFFFF, 5, 1'b1, p1);
        rx_send(16'hA572, 16, 1'b1, p2);
        total++; if (p1 != 0) begin bad++; $display("FAIL abort_partial_valid got=%0d want=0", p1); end
        total++; if (p2 != 1) begin bad++; $display("FAIL abort_full_valid got=%0d want=1", p2); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL abort_rx_data got=%h want=a5", rx_data); end
        total++; if (rx_crc_ok !== 1'b1) begin bad++; $display("FAIL abort_crc_ok got=%0h want=1", rx_crc_ok); end
        total++; if (rx_err_cnt !== 16'd1) begin bad++; $display("FAIL abort_err_cnt got=%0h want=1", rx_err_cnt); end
    endtask

    task automatic test_hunt;
        int p;
        rx_send(16'h0100, 16, 1'b0, p);
        total++; if (p != 0) begin bad++; $display("FAIL hunt_rx_valid got=%0d want=0", p); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL hunt_rx_data_hold got=%h want=a5", rx_data); end
        total++; if (rx_err_cnt !== 16'd1) begin bad++; $display("FAIL hunt_err_cnt got=%0h want=1", rx_err_cnt); end
    endtask

    task automatic test_saturation;
        int p;
        force dut.rx_err_q = 16'hFFFE;
        tick();
        release dut.rx_err_q;
        tick();
        rx_send(16'h0100, 16, 1'b1, p);
        total++; if (rx_err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h want=ffff", rx_err_cnt); end
        rx_send(16'h0100, 16, 1'b1, p);
        total++; if (rx_err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", rx_err_cnt); end
        total++; if (rx_crc_ok !== 1'b0) begin bad++; $display("FAIL sat_crc_ok got=%0h want=0", rx_crc_ok); end
    endtask

    task automatic test_reset_mid;
        int n, strobes, holderr, p;
        logic [15:0] seq;
        logic [15:0] part;
        part = 16'hA572;
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_sym_valid = 1'b1; rx_sym = part[15-i]; rx_sof = (i == 0);
            tick();
        end
        rx_sym_valid = 1'b0; rx_sof = 1'b0;
        repeat (7 * 16 - 2) tick();
        total++; if (tx_active !== 1'b1) begin bad++; $display("FAIL mid_active_before got=%0h want=1", tx_active); end
        #2 reset = 1'b0;
        #1;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_tx_ready got=%0h want=1", tx_ready); end
        total++; if (tx_active !== 1'b0) begin bad++; $display("FAIL mid_tx_active got=%0h want=0", tx_active); end
        total++; if (sym_strobe !== 1'b0) begin bad++; $display("FAIL mid_sym_strobe got=%0h want=0", sym_strobe); end
        total++; if (tx_sym !== 1'b0) begin bad++; $display("FAIL mid_tx_sym got=%0h want=0", tx_sym); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rx_valid got=%0h want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data got=%h want=00", rx_data); end
        total++; if (rx_crc_ok !== 1'b0) begin bad++; $display("FAIL mid_rx_crc_ok got=%0h want=0", rx_crc_ok); end
        total++; if (rx_err_cnt !== 16'h0) begin bad++; $display("FAIL mid_rx_err_cnt got=%h want=0", rx_err_cnt); end
        #2 reset = 1'b1;
        tick();
        tx_data = 8'h5A; tx_valid = 1'b1;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%0h want=1", tx_ready); end
        tick();
        tx_valid = 1'b0;
        collect2(n, strobes, holderr, seq);
        total++; if (seq !== 16'h5A81) begin bad++; $display("FAIL mid_clean_frame got=%h want=5a81", seq); end
        total++; if (n != 256) begin bad++; $display("FAIL mid_clean_len got=%0d want=256", n); end
        rx_send(part, 11, 1'b0, p);
        total++; if (p != 0) begin bad++; $display("FAIL mid_rx_discard got=%0d want=0", p); end
    endtask

    initial begin
        test_reset();
        test_tx_2fsk();
        test_tx_4fsk();
        test_back_to_back();
        test_loopback();
        test_rx_bad();
        test_abort();
        test_hunt();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
